packet_scheduler: RTL and testbench

PACKET_SCHEDULER -- requirements
Module: packet_scheduler

---
 rtl/hdmi_packet_pkg.sv | 41 ++++
 rtl/rr_arbiter.sv | 38 +++
 rtl/packet_scheduler.sv | 183 ++++++++++++++++++
 tb/tb_packet_scheduler.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/hdmi_packet_pkg.sv
// Shared HDMI packet-scheduler definitions: packet type codes, grant bit map, FSM states.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package hdmi_packet_pkg;

  // HDMI packet type codes
  localparam logic [7:0] PT_NULL     = 8'h00;
  localparam logic [7:0] PT_ACR      = 8'h01;
  localparam logic [7:0] PT_AUDIO    = 8'h02;
  localparam logic [7:0] PT_AVI      = 8'h82;
  localparam logic [7:0] PT_AUDIO_IF = 8'h84;
  localparam logic [7:0] PT_SPD      = 8'h83;
  localparam logic [7:0] PT_VSIF     = 8'h81;
  localparam logic [7:0] PT_HDR      = 8'h87;
  localparam logic [7:0] PT_EMP      = 8'h7F;

  // Grant vector layout: ACR, audio sample, then one bit per infoframe slot
  localparam int NUM_IF    = 6;
  localparam int GNT_ACR   = 0;
  localparam int GNT_AUDIO = 1;
  localparam int GNT_IF0   = 2;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_SEND = 1'b1
  } sched_state_t;

  // Infoframe slot index -> packet type code
  function automatic logic [7:0] infoframe_type(input logic [2:0] idx);
    case (idx)
      3'd0:    infoframe_type = PT_AVI;
      3'd1:    infoframe_type = PT_AUDIO_IF;
      3'd2:    infoframe_type = PT_SPD;
      3'd3:    infoframe_type = PT_VSIF;
      3'd4:    infoframe_type = PT_HDR;
      3'd5:    infoframe_type = PT_EMP;
      default: infoframe_type = PT_NULL;
    endcase
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin pick among 6 infoframe requests, starting at the slot after i_ptr.
// Latency: 0 (combinational).
// Backpressure: none; o_gnt is all-zero when nothing is requested.
// Ports: i_req  - request per infoframe slot
//        i_ptr  - last granted slot (0..5); search begins at i_ptr+1, wrapping 5->0
//        o_gnt  - one-hot grant
import hdmi_packet_pkg::*;

module rr_arbiter (
  input  logic [NUM_IF-1:0] i_req,
  input  logic [2:0]        i_ptr,
  output logic [NUM_IF-1:0] o_gnt
);

  logic       w_found;
  logic [3:0] w_sum;
  logic [2:0] w_idx;

  always_comb begin
    o_gnt   = '0;
    w_found = 1'b0;
    w_sum   = '0;
    w_idx   = '0;
    // k = NUM_IF revisits i_ptr itself last, so the last winner only wins again if alone
    for (int k = 1; k <= NUM_IF; k++) begin
      w_sum = {1'b0, i_ptr} + 4'(k);
      if (w_sum >= 4'(NUM_IF)) begin
        w_sum = w_sum - 4'(NUM_IF);
      end
      w_idx = w_sum[2:0];
      if (!w_found && i_req[w_idx]) begin
        o_gnt[w_idx] = 1'b1;
        w_found      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/packet_scheduler.sv
// HDMI data-island packet scheduler: picks ACR > audio > round-robin infoframe > null per slot.
// Latency: 1 cycle from packet_enable to registered packet_type/grant/audio_taken.
// Backpressure: none; packet_enable during an active slot is dropped and flagged in overlap_err.
// Ports: clk_pixel, reset_n (async, active-low)
//        video_field_end, packet_enable, acr_toggle, audio_ready  - scheduling inputs
//        packet_type, grant, audio_taken, slot_active              - per-slot outputs
//        missed, overlap_err                                        - sticky status
import hdmi_packet_pkg::*;

module packet_scheduler #(
  parameter logic [5:0] INFOFRAME_MASK = 6'b000111,
  parameter int         PACKET_CYCLES  = 32
) (
  input  logic       clk_pixel,
  input  logic       reset_n,
  input  logic       video_field_end,
  input  logic       packet_enable,
  input  logic       acr_toggle,
  input  logic       audio_ready,
  output logic       audio_taken,
  output logic [7:0] packet_type,
  output logic [7:0] grant,
  output logic       slot_active,
  output logic [5:0] missed,
  output logic       overlap_err
);

  localparam int CW = (PACKET_CYCLES > 1) ? $clog2(PACKET_CYCLES) : 1;

  sched_state_t      r_state;
  logic [CW-1:0]     r_cnt;
  logic              r_acr_ref;
  logic              r_acr_vld;
  logic              r_acr_pending;
  logic [NUM_IF-1:0] r_sent;
  logic [2:0]        r_rr_ptr;
  logic [7:0]        r_packet_type;
  logic [7:0]        r_grant;
  logic              r_audio_taken;
  logic [NUM_IF-1:0] r_missed;
  logic              r_overlap_err;

  logic              w_arb;
  logic              w_acr_edge;
  logic [NUM_IF-1:0] w_sent_eff;
  logic [NUM_IF-1:0] w_if_req;
  logic [NUM_IF-1:0] w_if_gnt;
  logic [2:0]        w_if_idx;
  logic              w_gnt_acr;
  logic              w_gnt_audio;
  logic              w_gnt_if;
  logic [7:0]        w_type_nxt;
  logic [7:0]        w_grant_nxt;

  // The first sample after reset only seeds the reference level
  assign w_acr_edge = r_acr_vld && (acr_toggle != r_acr_ref);

  assign w_arb = (r_state == ST_IDLE) && packet_enable;

  // A field end in the arbitration cycle already counts as the new field
  assign w_sent_eff = video_field_end ? '0 : r_sent;
  assign w_if_req   = INFOFRAME_MASK & ~w_sent_eff;

  rr_arbiter u_rr (
    .i_req (w_if_req),
    .i_ptr (r_rr_ptr),
    .o_gnt (w_if_gnt)
  );

  assign w_gnt_acr   = w_arb && r_acr_pending;
  assign w_gnt_audio = w_arb && !r_acr_pending && audio_ready;
  assign w_gnt_if    = w_arb && !r_acr_pending && !audio_ready && (|w_if_gnt);

  always_comb begin
    w_if_idx = '0;
    for (int i = 0; i < NUM_IF; i++) begin
      if (w_if_gnt[i]) begin
        w_if_idx = 3'(i);
      end
    end
  end

  always_comb begin
    w_type_nxt  = PT_NULL;
    w_grant_nxt = '0;
    if (w_gnt_acr) begin
      w_type_nxt           = PT_ACR;
      w_grant_nxt[GNT_ACR] = 1'b1;
    end else if (w_gnt_audio) begin
      w_type_nxt             = PT_AUDIO;
      w_grant_nxt[GNT_AUDIO] = 1'b1;
    end else if (w_gnt_if) begin
      w_type_nxt                       = infoframe_type(w_if_idx);
      w_grant_nxt[GNT_IF0 +: NUM_IF]   = w_if_gnt;
    end
  end

  // Slot FSM
  always_ff @(posedge clk_pixel or negedge reset_n) begin
    if (!reset_n) begin
      r_state       <= ST_IDLE;
      r_cnt         <= '0;
      r_overlap_err <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (packet_enable) begin
            r_state <= ST_SEND;
            r_cnt   <= CW'(PACKET_CYCLES - 1);
          end
        end
        ST_SEND: begin
          if (packet_enable) begin
            r_overlap_err <= 1'b1;
          end
          if (r_cnt == '0) begin
            r_state <= ST_IDLE;
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  // Arbitration results, held until the next arbitration
  always_ff @(posedge clk_pixel or negedge reset_n) begin
    if (!reset_n) begin
      r_packet_type <= PT_NULL;
      r_grant       <= '0;
      r_audio_taken <= 1'b0;
      r_rr_ptr      <= 3'd5;
    end else begin
      r_audio_taken <= w_gnt_audio;
      if (w_arb) begin
        r_packet_type <= w_type_nxt;
        r_grant       <= w_grant_nxt;
      end
      if (w_gnt_if) begin
        r_rr_ptr <= w_if_idx;
      end
    end
  end

  // ACR request tracking; an edge landing in the grant cycle stays pending
  always_ff @(posedge clk_pixel or negedge reset_n) begin
    if (!reset_n) begin
      r_acr_ref     <= 1'b0;
      r_acr_vld     <= 1'b0;
      r_acr_pending <= 1'b0;
    end else begin
      r_acr_ref <= acr_toggle;
      r_acr_vld <= 1'b1;
      if (w_gnt_acr) begin
        r_acr_pending <= w_acr_edge;
      end else if (w_acr_edge) begin
        r_acr_pending <= 1'b1;
      end
    end
  end

  // Per-field infoframe bookkeeping; missed looks at the flags from before the clear
  always_ff @(posedge clk_pixel or negedge reset_n) begin
    if (!reset_n) begin
      r_sent   <= '0;
      r_missed <= '0;
    end else begin
      r_sent <= w_sent_eff | ({NUM_IF{w_gnt_if}} & w_if_gnt);
      if (video_field_end) begin
        r_missed <= r_missed | (INFOFRAME_MASK & ~r_sent);
      end
    end
  end

  assign packet_type = r_packet_type;
  assign grant       = r_grant;
  assign audio_taken = r_audio_taken;
  assign slot_active = (r_state == ST_SEND);
  assign missed      = r_missed;
  assign overlap_err = r_overlap_err;

endmodule

// File: tb/tb_packet_scheduler.sv
// Self-checking bench for packet_scheduler: slot-level vector table, corner-case sequences,
// then randomized traffic compared cycle by cycle against a behavioural model.
module tb_packet_scheduler;

  localparam logic [5:0] MASK = 6'b000111;
  localparam int         PC   = 32;

  logic       clk_pixel = 1'b0;
  logic       reset_n   = 1'b0;
  logic       video_field_end = 1'b0;
  logic       packet_enable   = 1'b0;
  logic       acr_toggle      = 1'b0;
  logic       audio_ready     = 1'b0;
  logic       audio_taken;
  logic [7:0] packet_type;
  logic [7:0] grant;
  logic       slot_active;
  logic [5:0] missed;
  logic       overlap_err;

  packet_scheduler #(.INFOFRAME_MASK(MASK), .PACKET_CYCLES(PC)) dut (
    .clk_pixel       (clk_pixel),
    .reset_n         (reset_n),
    .video_field_end (video_field_end),
    .packet_enable   (packet_enable),
    .acr_toggle      (acr_toggle),
    .audio_ready     (audio_ready),
    .audio_taken     (audio_taken),
    .packet_type     (packet_type),
    .grant           (grant),
    .slot_active     (slot_active),
    .missed          (missed),
    .overlap_err     (overlap_err)
  );

  always #5 clk_pixel = ~clk_pixel;

  int n_chk  = 0;
  int n_pass = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  // ---------------- behavioural model (slot/field level rules) ----------------
  logic [7:0] ifc [6];
  logic [7:0] m_type, m_grant;
  logic       m_taken, m_ovl, m_pend, m_ref, m_refv;
  logic [5:0] m_missed, m_sent;
  int         m_busy, m_last;

  task automatic model_reset();
    m_type = 8'h00; m_grant = 8'h00; m_taken = 1'b0; m_ovl = 1'b0; m_pend = 1'b0;
    m_ref = 1'b0; m_refv = 1'b0; m_missed = '0; m_sent = '0; m_busy = 0; m_last = 5;
  endtask

  task automatic model_step();
    logic       edge_seen, got_acr;
    logic [5:0] sent_pre, sent_use;
    int         gif, i;
    if (!reset_n) begin
      model_reset();
    end else begin
      edge_seen = m_refv && (acr_toggle != m_ref);
      m_ref = acr_toggle; m_refv = 1'b1;
      got_acr = 1'b0; m_taken = 1'b0; gif = -1;
      sent_pre = m_sent;
      sent_use = video_field_end ? 6'b0 : m_sent;
      if (m_busy == 0 && packet_enable) begin
        if (m_pend) begin
          m_type = 8'h01; m_grant = 8'h01; got_acr = 1'b1;
        end else if (audio_ready) begin
          m_type = 8'h02; m_grant = 8'h02; m_taken = 1'b1;
        end else begin
          m_type = 8'h00; m_grant = 8'h00;
          for (int k = 1; k <= 6; k++) begin
            i = (m_last + k) % 6;
            if (gif < 0 && MASK[i] && !sent_use[i]) gif = i;
          end
          if (gif >= 0) begin
            m_type = ifc[gif]; m_grant = 8'(1 << (2 + gif)); m_last = gif;
          end
        end
        m_busy = PC;
      end else if (m_busy > 0) begin
        if (packet_enable) m_ovl = 1'b1;
        m_busy--;
      end
      m_pend = got_acr ? edge_seen : (m_pend | edge_seen);
      if (video_field_end) begin
        m_missed = m_missed | (MASK & ~sent_pre);
        m_sent = '0;
      end
      if (gif >= 0) m_sent[gif] = 1'b1;
    end
  endtask

  // One clock: inputs were driven before the edge; sample #1 after it
  task automatic tick();
    @(posedge clk_pixel);
    #1;
    model_step();
  endtask

  task automatic do_reset();
    reset_n = 1'b0; packet_enable = 1'b0; video_field_end = 1'b0; audio_ready = 1'b0;
    tick(); tick();
    reset_n = 1'b1;
    tick(); tick();
  endtask

  task automatic pe_pulse(input logic fe);
    video_field_end = fe; packet_enable = 1'b1;
    tick();
    packet_enable = 1'b0; video_field_end = 1'b0;
  endtask

  task automatic finish_slot();
    repeat (PC) tick();
  endtask

  // ---------------- slot-level vector table ----------------
  typedef struct {
    logic       do_acr;
    logic       aud;
    logic       fe_before;
    logic       fe_with_pe;
    logic [7:0] e_type;
    logic [7:0] e_grant;
    logic       e_taken;
    logic [5:0] e_missed;
  } vec_t;

  vec_t vecs[9];

  logic [24:0] act_v, exp_v;
  int          act_cnt;

  initial begin
    ifc[0] = 8'h82; ifc[1] = 8'h84; ifc[2] = 8'h83;
    ifc[3] = 8'h81; ifc[4] = 8'h87; ifc[5] = 8'h7F;
    model_reset();

    vecs[0] = '{1'b1, 1'b1, 1'b0, 1'b0, 8'h01, 8'h01, 1'b0, 6'b000000}; // ACR beats audio
    vecs[1] = '{1'b0, 1'b1, 1'b0, 1'b0, 8'h02, 8'h02, 1'b1, 6'b000000}; // then audio
    vecs[2] = '{1'b0, 1'b0, 1'b0, 1'b0, 8'h82, 8'h04, 1'b0, 6'b000000}; // AVI
    vecs[3] = '{1'b0, 1'b0, 1'b0, 1'b0, 8'h84, 8'h08, 1'b0, 6'b000000}; // Audio IF
    vecs[4] = '{1'b0, 1'b0, 1'b0, 1'b0, 8'h83, 8'h10, 1'b0, 6'b000000}; // SPD
    vecs[5] = '{1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 6'b000000}; // all sent -> null
    vecs[6] = '{1'b0, 1'b0, 1'b0, 1'b1, 8'h82, 8'h04, 1'b0, 6'b000000}; // field end + enable
    vecs[7] = '{1'b0, 1'b0, 1'b0, 1'b0, 8'h84, 8'h08, 1'b0, 6'b000000};
    vecs[8] = '{1'b0, 1'b0, 1'b1, 1'b0, 8'h83, 8'h10, 1'b0, 6'b000100}; // SPD missed last field

    // Reset state
    tick();
    act_v = {packet_type, grant, audio_taken, slot_active, missed, overlap_err};
    check("reset_outputs", 32'(act_v), 32'd0);
    reset_n = 1'b1;
    tick(); tick();

    for (int v = 0; v < 9; v++) begin
      if (vecs[v].fe_before) begin
        video_field_end = 1'b1; tick(); video_field_end = 1'b0;
      end
      if (vecs[v].do_acr) begin
        acr_toggle = ~acr_toggle; tick(); tick();
      end
      audio_ready = vecs[v].aud;
      pe_pulse(vecs[v].fe_with_pe);
      check($sformatf("vec%0d_type", v),   32'(packet_type), 32'(vecs[v].e_type));
      check($sformatf("vec%0d_grant", v),  32'(grant),       32'(vecs[v].e_grant));
      check($sformatf("vec%0d_taken", v),  32'(audio_taken), 32'(vecs[v].e_taken));
      check($sformatf("vec%0d_missed", v), 32'(missed),      32'(vecs[v].e_missed));
      audio_ready = 1'b0;
      tick();
      check($sformatf("vec%0d_taken_pulse", v), 32'(audio_taken), 32'd0);
      finish_slot();
      check($sformatf("vec%0d_idle", v), 32'(slot_active), 32'd0);
    end

    // Field with only AVI sent -> Audio IF and SPD missed, and they stay sticky
    do_reset();
    pe_pulse(1'b0);
    check("avi_only_type", 32'(packet_type), 32'h82);
    finish_slot();
    video_field_end = 1'b1; tick(); video_field_end = 1'b0;
    check("missed_after_field", 32'(missed), 32'b000110);
    tick();
    video_field_end = 1'b1; tick(); video_field_end = 1'b0;
    check("missed_sticky", 32'(missed), 32'b000111);

    // Overlapping enable 10 cycles into a slot
    do_reset();
    pe_pulse(1'b0);
    act_cnt = int'(slot_active);
    for (int i = 1; i < 45; i++) begin
      if (i == 10) packet_enable = 1'b1;
      tick();
      packet_enable = 1'b0;
      if (i == 10) begin
        check("overlap_err_set", 32'(overlap_err), 32'd1);
        check("overlap_type_held", 32'(packet_type), 32'h82);
        check("overlap_grant_held", 32'(grant), 32'h04);
      end
      act_cnt += int'(slot_active);
    end
    check("slot_active_cycles", 32'(act_cnt), 32'(PC));

    // Field end and enable together with every infoframe already sent
    do_reset();
    for (int s = 0; s < 3; s++) begin
      pe_pulse(1'b0); finish_slot();
    end
    pe_pulse(1'b1);
    check("fe_pe_type", 32'(packet_type), 32'h82);
    check("fe_pe_grant", 32'(grant), 32'h04);
    check("fe_pe_missed", 32'(missed), 32'd0);
    finish_slot();
    video_field_end = 1'b1; tick(); video_field_end = 1'b0;
    check("fe_pe_sent0_new_field", 32'(missed), 32'b000110);

    // Reset mid-slot, with an acr_toggle change held through release
    do_reset();
    pe_pulse(1'b0);
    for (int i = 1; i < 15; i++) begin
      if (i == 5) packet_enable = 1'b1;
      tick();
      packet_enable = 1'b0;
    end
    check("pre_reset_overlap", 32'(overlap_err), 32'd1);
    #2;
    acr_toggle = ~acr_toggle;
    reset_n = 1'b0;
    #1;
    check("reset_slot_active", 32'(slot_active), 32'd0);
    act_v = {packet_type, grant, audio_taken, slot_active, missed, overlap_err};
    check("reset_mid_outputs", 32'(act_v), 32'd0);
    tick(); tick();
    reset_n = 1'b1;
    tick(); tick();
    pe_pulse(1'b0);
    check("no_acr_after_reset_type", 32'(packet_type), 32'h82);
    check("no_acr_after_reset_grant", 32'(grant), 32'h04);
    finish_slot();

    // Randomized traffic against the model
    do_reset();
    for (int c = 0; c < 4000; c++) begin
      reset_n         = ($urandom_range(0, 799) != 0);
      packet_enable   = ($urandom_range(0, 7) == 0);
      video_field_end = ($urandom_range(0, 149) == 0);
      audio_ready     = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 19) == 0) acr_toggle = ~acr_toggle;
      tick();
      exp_v = {m_type, m_grant, m_taken, (m_busy > 0), m_missed, m_ovl};
      act_v = {packet_type, grant, audio_taken, slot_active, missed, overlap_err};
      check($sformatf("rand_cycle%0d", c), 32'(act_v), 32'(exp_v));
    end
    reset_n = 1'b1; packet_enable = 1'b0; video_field_end = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
